// File: rtl/sprite_row_display_pkg.sv
// Shared constants, FSM state type and the procedural sprite image for the sprite row overlay.
package sprite_row_display_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned VActive = 480;

  localparam logic [15:0] ColBlack      = 16'h0000;
  localparam logic [15:0] TranspKeyDflt = 16'hF81F;

  typedef enum logic {
    StIdle  = 1'b0,
    StBlink = 1'b1
  } blink_st_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  // 16x16 image: anti-diagonal is the transparency key, the rest encodes (x, y) in RGB565.
  function automatic logic [15:0] sprite_pixel(input int unsigned x, input int unsigned y);
    if (x + y == 32'd15) return TranspKeyDflt;
    return {1'b0, 4'(y), 1'b1, 4'(x), 6'h00};
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous-read sprite image ROM, one clock of latency.
module sprite_rom
  import sprite_row_display_pkg::*;
#(
  parameter int unsigned ImgW = 16,
  parameter int unsigned ImgH = 16,
  localparam int unsigned XW = $clog2(ImgW),
  localparam int unsigned YW = $clog2(ImgH)
) (
  input  logic          clk_i,
  input  logic [XW-1:0] pixel_x_i,
  input  logic [YW-1:0] pixel_y_i,
  output logic [15:0]   rgb_data_o
);

  logic [15:0] rgb_data_q;

  always_ff @(posedge clk_i) begin
    rgb_data_q <= sprite_pixel(32'(pixel_x_i), 32'(pixel_y_i));
  end

  assign rgb_data_o = rgb_data_q;

endmodule

// File: rtl/sprite_row_display.sv
// Row of up to NumSprites scaled ROM sprites with transparency key and lost-sprite blink.
module sprite_row_display
  import sprite_row_display_pkg::*;
#(
  parameter int unsigned ImgW        = 16,
  parameter int unsigned ImgH        = 16,
  parameter int unsigned ScaleShift  = 1,
  parameter int unsigned NumSprites  = 5,
  parameter int unsigned Gap         = 8,
  parameter logic [9:0]  PosXRst     = 10'd16,
  parameter logic [9:0]  PosYRst     = 10'd16,
  parameter logic [9:0]  LatchLine   = 10'(VActive),
  parameter int unsigned BlinkPeriod = 8,
  parameter int unsigned BlinkFrames = 64,
  parameter logic [15:0] TranspKey   = TranspKeyDflt
) (
  input  logic        vga_clk_i,
  input  logic        sys_rst_n_i,
  input  logic [9:0]  vga_x_i,
  input  logic [9:0]  vga_y_i,
  input  logic        video_on_i,
  input  logic [9:0]  pos_x_i,
  input  logic [9:0]  pos_y_i,
  input  logic [2:0]  lives_i,
  input  logic        blink_en_i,
  output logic [15:0] rgb_o,
  output logic        hit_o
);

  localparam int unsigned DispW = ImgW << ScaleShift;
  localparam int unsigned DispH = ImgH << ScaleShift;
  localparam int unsigned Pitch = DispW + Gap;
  localparam int unsigned XW    = $clog2(ImgW);
  localparam int unsigned YW    = $clog2(ImgH);
  localparam int unsigned FcW   = $clog2(BlinkFrames);

  // Frame-synchronous state
  blink_st_e      st_q;
  pos_t           pos_q;
  logic [2:0]     lives_q;
  logic [2:0]     blink_slot_q;
  logic [FcW-1:0] frame_cnt_q;
  logic           phase_q;

  logic           latch;
  logic [2:0]     lives_sat;
  logic [FcW-1:0] cnt_inc;

  assign latch     = (vga_y_i == LatchLine) && (vga_x_i == 10'd0);
  assign lives_sat = (lives_i > 3'(NumSprites)) ? 3'(NumSprites) : lives_i;
  assign cnt_inc   = frame_cnt_q + 1'b1;

  always_ff @(posedge vga_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      st_q         <= StIdle;
      pos_q        <= '{x: PosXRst, y: PosYRst};
      lives_q      <= '0;
      blink_slot_q <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else if (latch) begin
      lives_q <= lives_sat;
      pos_q   <= '{x: pos_x_i, y: pos_y_i};
      case (st_q)
        StIdle: begin
          if (blink_en_i && (lives_sat < lives_q)) begin
            st_q         <= StBlink;
            blink_slot_q <= lives_sat;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
          end
        end
        StBlink: begin
          if (!blink_en_i) begin
            st_q <= StIdle;
          end else if (lives_sat < lives_q) begin
            // Only the lowest newly lost slot blinks; any higher ones are already hidden.
            blink_slot_q <= lives_sat;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
          end else if ((lives_sat > blink_slot_q) ||
                       (frame_cnt_q == FcW'(BlinkFrames - 1))) begin
            st_q <= StIdle;
          end else begin
            frame_cnt_q <= cnt_inc;
            if ((cnt_inc % FcW'(BlinkPeriod)) == '0) phase_q <= ~phase_q;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  // Geometry
  logic [9:0]            rel_x, rel_y;
  logic [NumSprites-1:0] slot_hit;
  logic [2:0]            slot;
  logic [9:0]            slot_off;
  logic                  in_area;

  assign rel_x = vga_x_i - pos_q.x;
  assign rel_y = vga_y_i - pos_q.y;

  for (genvar k = 0; k < NumSprites; k++) begin : g_slot
    assign slot_hit[k] = (rel_x >= 10'(k * Pitch)) && (rel_x < 10'(k * Pitch + DispW));
  end

  always_comb begin
    slot     = '0;
    slot_off = '0;
    for (int unsigned k = 0; k < NumSprites; k++) begin
      if (slot_hit[k]) begin
        slot     = 3'(k);
        slot_off = rel_x - 10'(k * Pitch);
      end
    end
  end

  assign in_area = (vga_x_i >= pos_q.x) && (vga_y_i >= pos_q.y) && (rel_y < 10'(DispH)) &&
                   (|slot_hit) && (vga_x_i < 10'(HActive)) && (vga_y_i < 10'(VActive));

  // S1
  logic [2:0]    s1_slot_q;
  logic [XW-1:0] s1_img_x_q;
  logic [YW-1:0] s1_img_y_q;
  logic          s1_in_area_q, s1_video_on_q;

  always_ff @(posedge vga_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      s1_slot_q     <= '0;
      s1_img_x_q    <= '0;
      s1_img_y_q    <= '0;
      s1_in_area_q  <= 1'b0;
      s1_video_on_q <= 1'b0;
    end else begin
      s1_slot_q     <= slot;
      s1_img_x_q    <= XW'(slot_off >> ScaleShift);
      s1_img_y_q    <= YW'(rel_y >> ScaleShift);
      s1_in_area_q  <= in_area;
      s1_video_on_q <= video_on_i;
    end
  end

  // S2: ROM read in parallel with visibility decision
  logic [15:0] rom_data;
  logic        visible;
  logic        s2_visible_q, s2_in_area_q, s2_video_on_q;

  sprite_rom #(
    .ImgW(ImgW),
    .ImgH(ImgH)
  ) u_sprite_rom (
    .clk_i     (vga_clk_i),
    .pixel_x_i (s1_img_x_q),
    .pixel_y_i (s1_img_y_q),
    .rgb_data_o(rom_data)
  );

  assign visible = (s1_slot_q < lives_q) ||
                   ((st_q == StBlink) && (s1_slot_q == blink_slot_q) && phase_q);

  always_ff @(posedge vga_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      s2_visible_q  <= 1'b0;
      s2_in_area_q  <= 1'b0;
      s2_video_on_q <= 1'b0;
    end else begin
      s2_visible_q  <= visible;
      s2_in_area_q  <= s1_in_area_q;
      s2_video_on_q <= s1_video_on_q;
    end
  end

  // S3
  logic        hit_d, hit_q;
  logic [15:0] rgb_d, rgb_q;

  assign hit_d = s2_video_on_q && s2_in_area_q && s2_visible_q && (rom_data != TranspKey);
  assign rgb_d = hit_d ? rom_data : ColBlack;

  always_ff @(posedge vga_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rgb_q <= ColBlack;
      hit_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
    end
  end

  assign rgb_o = rgb_q;
  assign hit_o = hit_q;

endmodule

// File: tb/tb_sprite_row_display.sv
// Randomized scoreboard bench for sprite_row_display with a frame-level reference model.
module tb_sprite_row_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  vga_x = '0, vga_y = '0, pos_x = 10'd16, pos_y = 10'd16;
  logic        video_on = 1'b0, blink_en = 1'b1;
  logic [2:0]  lives = '0;
  logic [15:0] rgb;
  logic        hit;

  sprite_row_display dut (
    .vga_clk_i  (clk),
    .sys_rst_n_i(rst_n),
    .vga_x_i    (vga_x),
    .vga_y_i    (vga_y),
    .video_on_i (video_on),
    .pos_x_i    (pos_x),
    .pos_y_i    (pos_y),
    .lives_i    (lives),
    .blink_en_i (blink_en),
    .rgb_o      (rgb),
    .hit_o      (hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          due;
    int          x;
    int          y;
    bit          hit;
    logic [15:0] rgb;
  } exp_t;
  exp_t sb[$];

  // Reference model state, updated once per latch
  int m_lives = 0, m_px = 16, m_py = 16;
  bit m_blink = 0;
  int m_bslot = 0, m_bf = 0;

  function automatic logic [15:0] rom_model(input int ix, input int iy);
    if (ix + iy == 15) return 16'hF81F;
    return 16'h0400 + 16'(ix * 64) + 16'(iy * 2048);
  endfunction

  function automatic void model_px(input int x, input int y, input bit von,
                                   output bit h, output logic [15:0] c);
    int rx, ry, k, col;
    bit vis;
    logic [15:0] p;
    h = 1'b0;
    c = 16'h0;
    if (!von || x >= 640 || y >= 480 || x < m_px || y < m_py) return;
    rx = x - m_px;
    ry = y - m_py;
    if (ry >= 32) return;
    k   = rx / 40;
    col = rx % 40;
    if (k >= 5 || col >= 32) return;
    vis = (k < m_lives) || (m_blink && k == m_bslot && ((m_bf / 8) % 2 == 1));
    if (!vis) return;
    p = rom_model(col / 2, ry / 2);
    if (p == 16'hF81F) return;
    h = 1'b1;
    c = p;
  endfunction

  function automatic void model_latch();
    int nl;
    nl = (int'(lives) > 5) ? 5 : int'(lives);
    if (m_blink) begin
      if (!blink_en) m_blink = 0;
      else if (nl < m_lives) begin
        m_bslot = nl;
        m_bf = 0;
      end else if (nl > m_bslot || m_bf == 63) m_blink = 0;
      else m_bf++;
    end else if (blink_en && nl < m_lives) begin
      m_blink = 1;
      m_bslot = nl;
      m_bf = 0;
    end
    m_lives = nl;
    m_px = int'(pos_x);
    m_py = int'(pos_y);
  endfunction

  function automatic void model_reset();
    m_lives = 0;
    m_px = 16;
    m_py = 16;
    m_blink = 0;
    m_bslot = 0;
    m_bf = 0;
  endfunction

  task automatic drive(input int x, input int y, input bit von);
    exp_t e;
    @(posedge clk);
    #1;
    vga_x    = 10'(x);
    vga_y    = 10'(y);
    video_on = von;
    e.due = cyc + 3;
    e.x   = int'(vga_x);
    e.y   = int'(vga_y);
    model_px(e.x, e.y, von, e.hit, e.rgb);
    sb.push_back(e);
    if (vga_y == 10'd480 && vga_x == 10'd0) model_latch();
  endtask

  // One compressed frame: the latch pixel, one pixel per slot, then random pixels near the row.
  task automatic frame(input int nrand);
    drive(0, 480, 1'b1);
    for (int k = 0; k <= 5; k++) drive(m_px + k * 40, m_py, 1'b1);
    for (int k = 0; k <= 5; k++)
      drive(m_px + k * 40 + 2 * int'($urandom_range(0, 15)), m_py + 2 * int'($urandom_range(0, 15)),
            1'b1);
    for (int i = 0; i < nrand; i++)
      drive(m_px - 8 + int'($urandom_range(0, 230)), m_py - 4 + int'($urandom_range(0, 40)),
            $urandom_range(0, 7) != 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (hit !== e.hit || rgb !== e.rgb || e.due != cyc) begin
          n_fail++;
          $display("FAIL px(%0d,%0d) got hit=%0b rgb=%h, expected hit=%0b rgb=%h", e.x, e.y,
                   hit, rgb, e.hit, e.rgb);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (rgb !== 16'h0 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got hit=%0b rgb=%h, expected hit=0 rgb=0000", hit, rgb);
    end
    rst_n = 1'b1;

    // Nothing visible before the first latch
    drive(16, 16, 1'b1);
    drive(100, 20, 1'b1);

    // Basic row with three lives
    lives = 3'd3;
    frame(10);
    drive(16, 16, 1'b1);
    drive(96, 16, 1'b1);
    drive(136, 16, 1'b1);
    for (int x = 48; x <= 55; x++) drive(x, 16, 1'b1);

    // Mid-frame position change must not take effect before the latch
    pos_x = 10'd200;
    drive(16, 16, 1'b1);
    drive(200, 16, 1'b1);
    frame(5);
    drive(200, 16, 1'b1);
    drive(16, 16, 1'b1);

    // Single decrement blinks slot 2 until the blink expires
    lives = 3'd2;
    for (int f = 0; f < 70; f++) frame(4);

    // Blink restart on further decrement, then cancel on increase
    lives = 3'd3;
    frame(4);
    lives = 3'd2;
    for (int f = 0; f < 10; f++) frame(4);
    lives = 3'd1;
    for (int f = 0; f < 12; f++) frame(4);
    lives = 3'd3;
    for (int f = 0; f < 3; f++) frame(4);

    // Transparent pixel, blanked video, saturation of lives
    drive(m_px + 30, m_py, 1'b1);
    drive(m_px + 31, m_py + 1, 1'b1);
    drive(m_px, m_py, 1'b0);
    lives = 3'd7;
    frame(6);
    drive(m_px + 160, m_py, 1'b1);
    drive(m_px + 200, m_py, 1'b1);

    // Asynchronous reset in the middle of a blink, mid-line
    lives = 3'd4;
    frame(2);
    for (int i = 0; i < 4; i++) drive(m_px + 2, m_py + 2, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rgb !== 16'h0 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got hit=%0b rgb=%h, expected hit=0 rgb=0000", hit, rgb);
    end
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lives = 3'd3;
    for (int f = 0; f < 3; f++) frame(6);

    // Random traffic
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 3) == 0) lives = 3'($urandom_range(0, 7));
      blink_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        pos_x = 10'($urandom_range(0, 700));
        pos_y = 10'($urandom_range(0, 500));
      end
      frame(12);
    end

    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
